// File: rtl/agc_alu_sequencer.sv
// AGC one's-complement ALU sequencer: single-cycle ADD/SUB,
// 14-step shift-add MP and restoring DV, valid/ready request/response.
module agc_alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [29:0] req_a,
    input  logic [14:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [14:0] res_a,
    output logic [14:0] res_l,
    output logic        res_ovf
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MP  = 2'b10;
    localparam logic [1:0] OP_DV  = 2'b11;

    function automatic logic [13:0] mag(input logic [14:0] x);
        return x[14] ? ~x[13:0] : x[13:0];
    endfunction

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        op_mp;
    logic [13:0] mc;
    logic [13:0] hi_r;
    logic [13:0] lo_r;
    logic        sign_q;
    logic        sign_r;

    logic        accept;
    logic [14:0] a_w;
    logic [14:0] hi_w;
    logic [14:0] b_eff;
    logic [15:0] as_raw;
    logic [14:0] as_sum;
    logic        as_ovf;
    logic [13:0] hi_mag;
    logic [13:0] lo_mag;
    logic [13:0] b_mag;
    logic        dsign;
    logic        qs;
    logic        dv_ovf;

    logic [14:0] mp_sum;
    logic [14:0] dv_t;
    logic        dv_ge;
    logic [13:0] dv_diff;
    logic [13:0] step_hi;
    logic [13:0] step_lo;
    logic [14:0] fin_a;
    logic [14:0] fin_l;

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == DONE);
    assign accept     = req_valid && req_ready;

    assign a_w  = req_a[14:0];
    assign hi_w = req_a[29:15];

    // End-around carry folds the 16th bit back into the sum.
    assign b_eff  = (req_op == OP_SUB) ? ~req_b : req_b;
    assign as_raw = {1'b0, a_w} + {1'b0, b_eff};
    assign as_sum = as_raw[14:0] + {14'd0, as_raw[15]};
    assign as_ovf = (a_w[14] == b_eff[14]) && (as_sum[14] != a_w[14]);

    assign hi_mag = mag(hi_w);
    assign lo_mag = mag(a_w);
    assign b_mag  = mag(req_b);
    assign dsign  = (hi_mag == 14'd0) ? a_w[14] : hi_w[14];
    assign qs     = dsign ^ req_b[14];
    assign dv_ovf = (b_mag == 14'd0) || (hi_mag >= b_mag);

    assign mp_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mc} : 15'd0);
    assign dv_t    = {hi_r, lo_r[13]};
    assign dv_ge   = dv_t >= {1'b0, mc};
    assign dv_diff = 14'(dv_t - {1'b0, mc});

    assign step_hi = op_mp ? mp_sum[14:1] : (dv_ge ? dv_diff : dv_t[13:0]);
    assign step_lo = op_mp ? {mp_sum[0], lo_r[13:1]} : {lo_r[12:0], dv_ge};

    // MP: hi/lo product words; DV: quotient in lo, remainder in hi.
    assign fin_a = op_mp ? {sign_q, step_hi ^ {14{sign_q}}}
                         : {sign_q, step_lo ^ {14{sign_q}}};
    assign fin_l = op_mp ? {sign_q, step_lo ^ {14{sign_q}}}
                         : {sign_r, step_hi ^ {14{sign_r}}};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (req_op)
                        OP_ADD, OP_SUB: state_nxt = DONE;
                        OP_MP:          state_nxt = ITER;
                        OP_DV:          state_nxt = dv_ovf ? DONE : ITER;
                    endcase
                end
            end
            ITER: if (cnt == 4'd0) state_nxt = DONE;
            DONE: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            op_mp   <= 1'b0;
            mc      <= 14'd0;
            hi_r    <= 14'd0;
            lo_r    <= 14'd0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            res_a   <= 15'd0;
            res_l   <= 15'd0;
            res_ovf <= 1'b0;
        end else if (accept) begin
            cnt   <= 4'd13;
            op_mp <= (req_op == OP_MP);
            unique case (req_op)
                OP_ADD, OP_SUB: begin
                    res_a   <= as_sum;
                    res_l   <= 15'd0;
                    res_ovf <= as_ovf;
                end
                OP_MP: begin
                    mc     <= mag(a_w);
                    hi_r   <= 14'd0;
                    lo_r   <= b_mag;
                    sign_q <= a_w[14] ^ req_b[14];
                    sign_r <= a_w[14] ^ req_b[14];
                end
                OP_DV: begin
                    mc     <= b_mag;
                    hi_r   <= hi_mag;
                    lo_r   <= lo_mag;
                    sign_q <= qs;
                    sign_r <= dsign;
                    if (dv_ovf) begin
                        res_a   <= {qs, 14'h3FFF ^ {14{qs}}};
                        res_l   <= 15'd0;
                        res_ovf <= 1'b1;
                    end
                end
            endcase
        end else if (state == ITER) begin
            hi_r <= step_hi;
            lo_r <= step_lo;
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else begin
                res_a   <= fin_a;
                res_l   <= fin_l;
                res_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_agc_alu_sequencer.sv
// Randomized bench for agc_alu_sequencer against an integer-arithmetic
// model of one's-complement ADD/SUB/MP/DV.
module tb_agc_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [29:0] req_a;
    logic [14:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [14:0] res_a;
    logic [14:0] res_l;
    logic        res_ovf;

    int checks = 0;
    int errors = 0;

    agc_alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .res_a      (res_a),
        .res_l      (res_l),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0o exp %0o", tag, got, exp);
        end
    endtask

    function automatic int oc_val(input logic [14:0] x);
        logic [13:0] m;
        m = x[14] ? ~x[13:0] : x[13:0];
        return x[14] ? -int'(m) : int'(m);
    endfunction

    function automatic int oc_mag(input logic [14:0] x);
        int v;
        v = oc_val(x);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [14:0] enc(input logic s, input int m);
        logic [13:0] mm;
        mm = m[13:0];
        return s ? {1'b1, ~mm} : {1'b0, mm};
    endfunction

    task automatic model(input logic [1:0] op, input logic [29:0] a,
                         input logic [14:0] b, output logic [14:0] ea,
                         output logic [14:0] el, output logic eo);
        logic [14:0] aw, hw, be;
        int s, hm, lm, bm, n;
        logic ds, qs, ps;
        aw = a[14:0];
        hw = a[29:15];
        ea = '0;
        el = '0;
        eo = 1'b0;
        case (op)
            2'd0, 2'd1: begin
                be = (op == 2'd1) ? ~b : b;
                s  = oc_val(aw) + oc_val(be);
                if (s > 16383) begin
                    s  = s - 32767;
                    eo = 1'b1;
                end else if (s < -16383) begin
                    s  = s + 32767;
                    eo = 1'b1;
                end
                if (s == 0)
                    ea = (aw == 15'd0 && be == 15'd0) ? 15'd0 : 15'h7FFF;
                else if (s > 0)
                    ea = enc(1'b0, s);
                else
                    ea = enc(1'b1, -s);
            end
            2'd2: begin
                ps = aw[14] ^ b[14];
                n  = oc_mag(aw) * oc_mag(b);
                ea = enc(ps, n / 16384);
                el = enc(ps, n % 16384);
            end
            default: begin
                hm = oc_mag(hw);
                lm = oc_mag(aw);
                bm = oc_mag(b);
                ds = (hm == 0) ? aw[14] : hw[14];
                qs = ds ^ b[14];
                if (bm == 0 || hm >= bm) begin
                    ea = enc(qs, 16383);
                    eo = 1'b1;
                end else begin
                    n  = hm * 16384 + lm;
                    ea = enc(qs, n / bm);
                    el = enc(ds, n % bm);
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [29:0] a,
                          input logic [14:0] b, input logic [14:0] ea,
                          input logic [14:0] el, input logic eo,
                          input int hold);
        int lat, n;
        lat = (op == 2'd2 || (op == 2'd3 && !eo)) ? 15 : 1;
        check("idle_ready", req_ready, 1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy_ready", req_ready, 0);
        n = 1;
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        check("res_a", res_a, ea);
        check("res_l", res_l, el);
        check("res_ovf", res_ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", resp_valid, 1);
            check("hold_ready", req_ready, 0);
            check("hold_a", res_a, ea);
            check("hold_l", res_l, el);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        check("ready_back", req_ready, 1);
    endtask

    task automatic rand_op;
        logic [1:0]  op;
        logic [14:0] a, b, hi, lo, ea, el;
        logic [13:0] bm, hm, lm;
        logic        hs, ls, eo;
        op = 2'($urandom_range(0, 3));
        b  = 15'($urandom);
        a  = 15'($urandom);
        hi = 15'd0;
        if (op == 2'd3) begin
            bm = b[14] ? ~b[13:0] : b[13:0];
            if (bm != 14'd0 && $urandom_range(0, 3) != 0)
                hm = 14'($urandom_range(0, int'(bm) - 1));
            else
                hm = 14'($urandom);
            hs = 1'($urandom);
            lm = 14'($urandom);
            ls = (hm == 14'd0) ? 1'($urandom) : hs;
            hi = hs ? {1'b1, ~hm} : {1'b0, hm};
            a  = ls ? {1'b1, ~lm} : {1'b0, lm};
        end
        model(op, {hi, a}, b, ea, el, eo);
        run_op(op, {hi, a}, b, ea, el, eo, $urandom_range(0, 2));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_a", res_a, 0);
        check("rst_l", res_l, 0);
        check("rst_ovf", res_ovf, 0);
        rst = 1'b0;
        #1;

        run_op(2'd0, {15'd0, 15'o00003}, 15'o00004, 15'o00007, 15'o0, 1'b0, 0);
        run_op(2'd1, {15'd0, 15'o00003}, 15'o00004, 15'o77776, 15'o0, 1'b0, 0);
        run_op(2'd0, {15'd0, 15'o37777}, 15'o00001, 15'o40000, 15'o0, 1'b1, 1);
        run_op(2'd2, {15'd0, 15'o00003}, 15'o77773, 15'o77777, 15'o77763, 1'b0, 3);
        run_op(2'd2, {15'd0, 15'o00000}, 15'o77777, 15'o77777, 15'o77777, 1'b0, 0);
        run_op(2'd3, {15'o00000, 15'o00144}, 15'o00007, 15'o00016, 15'o00002, 1'b0, 0);
        run_op(2'd3, {15'o77777, 15'o77633}, 15'o00007, 15'o77761, 15'o77775, 1'b0, 1);
        run_op(2'd3, {15'o00010, 15'o00000}, 15'o00007, 15'o37777, 15'o0, 1'b1, 0);
        run_op(2'd3, {15'o00000, 15'o00005}, 15'o00000, 15'o37777, 15'o0, 1'b1, 0);

        for (int i = 0; i < 200; i++) rand_op();

        req_op    = 2'd2;
        req_a     = {15'd0, 15'o01234};
        req_b     = 15'o00567;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_a", res_a, 0);
        check("mid_rst_l", res_l, 0);
        check("mid_rst_ovf", res_ovf, 0);
        check("mid_rst_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);
        repeat (16) @(posedge clk);
        #1;
        check("no_resp", resp_valid, 0);

        run_op(2'd0, {15'd0, 15'o00001}, 15'o77776, 15'o77777, 15'o0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
